// File: rtl/axil_arb_pkg.sv
// Shared encodings for the 2:1 AXI4-Lite arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/axil_arbiter_2to1_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time wins.
module rr_arb2
  import axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx,
  output logic       gnt_valid
);

  // pure combinational pick; the caller registers the result
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT0;
    case (req)
      2'b01:   gnt_idx = PORT0;
      2'b10:   gnt_idx = PORT1;
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = PORT0;
    endcase
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Two AXI4-Lite masters sharing one AXI4-Lite slave, one transaction in flight.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | pick a requester (round-robin), no downstream valid
//   RD_ADDR | forwarding AR of the granted port
//   RD_DATA | forwarding R back to the granted port
//   WR_ADDR | forwarding AW and W; each channel completes independently
//   WR_RESP | forwarding B back to the granted port
module axil_arbiter_2to1
  import axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [2:0]          s0_awprot,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  output logic                s0_bvalid,
  input  logic                s0_bready,
  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [ADDR_W-1:0]   s0_araddr,
  input  logic [2:0]          s0_arprot,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [DATA_W-1:0]   s0_rdata,

  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [2:0]          s1_awprot,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  output logic                s1_bvalid,
  input  logic                s1_bready,
  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [ADDR_W-1:0]   s1_araddr,
  input  logic [2:0]          s1_arprot,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [DATA_W-1:0]   s1_rdata,

  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [2:0]          m_awprot,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [2:0]          m_arprot,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata
);

  state_t     state;
  logic       grant;
  logic       last_grant;
  logic       aw_done;
  logic       w_done;

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic       pick_idx;
  logic       pick_valid;
  logic       aw_hs;
  logic       w_hs;

  // a write needs both AW and W presented; a lone AW or W is not a request
  assign wr_req = {s1_awvalid & s1_wvalid, s0_awvalid & s0_wvalid};
  assign rd_req = {s1_arvalid, s0_arvalid};

  rr_arb2 u_rr_arb2 (
    .req       (wr_req | rd_req),
    .last      (last_grant),
    .gnt_idx   (pick_idx),
    .gnt_valid (pick_valid)
  );

  // payloads are not registered: masters hold them stable while valid
  assign m_awaddr = (grant == PORT1) ? s1_awaddr : s0_awaddr;
  assign m_awprot = (grant == PORT1) ? s1_awprot : s0_awprot;
  assign m_wdata  = (grant == PORT1) ? s1_wdata  : s0_wdata;
  assign m_wstrb  = (grant == PORT1) ? s1_wstrb  : s0_wstrb;
  assign m_araddr = (grant == PORT1) ? s1_araddr : s0_araddr;
  assign m_arprot = (grant == PORT1) ? s1_arprot : s0_arprot;

  // read data is broadcast; only rvalid qualifies it per port
  assign s0_rdata = m_rdata;
  assign s1_rdata = m_rdata;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;

  // handshake steering, gated by state so stray downstream responses are dropped
  always_comb begin
    m_awvalid  = (state == WR_ADDR) & ~aw_done;
    m_wvalid   = (state == WR_ADDR) & ~w_done;
    m_arvalid  = (state == RD_ADDR);
    m_bready   = (state == WR_RESP) & ((grant == PORT1) ? s1_bready : s0_bready);
    m_rready   = (state == RD_DATA) & ((grant == PORT1) ? s1_rready : s0_rready);

    s0_awready = aw_hs & (grant == PORT0);
    s1_awready = aw_hs & (grant == PORT1);
    s0_wready  = w_hs & (grant == PORT0);
    s1_wready  = w_hs & (grant == PORT1);
    s0_arready = m_arvalid & m_arready & (grant == PORT0);
    s1_arready = m_arvalid & m_arready & (grant == PORT1);
    s0_bvalid  = (state == WR_RESP) & m_bvalid & (grant == PORT0);
    s1_bvalid  = (state == WR_RESP) & m_bvalid & (grant == PORT1);
    s0_rvalid  = (state == RD_DATA) & m_rvalid & (grant == PORT0);
    s1_rvalid  = (state == RD_DATA) & m_rvalid & (grant == PORT1);
  end

  // transaction sequencer; last_grant only moves once a response completes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= PORT0;
      last_grant <= PORT1;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick_idx;
            state <= wr_req[pick_idx] ? WR_ADDR : RD_ADDR;
          end
        end
        RD_ADDR: begin
          if (m_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_rvalid & m_rready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        WR_ADDR: begin
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (m_bvalid & m_bready) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Bench for axil_arbiter_2to1: two master agents, one slave agent, transaction-level
// round-robin model predicting the downstream order.
module tb_axil_arbiter_2to1;

  localparam logic [31:0] RD_KEY = 32'hDDAD_8EEF;

  typedef struct packed {
    logic        wr;
    logic        pair;
    logic        port;
    logic [2:0]  prot;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;

  logic [1:0]  awvalid, wvalid, bready, arvalid, rready;
  wire  [1:0]  awready, wready, bvalid, arready, rvalid;
  logic [31:0] awaddr [2];
  logic [2:0]  awprot [2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic [31:0] araddr [2];
  logic [2:0]  arprot [2];
  wire  [31:0] rdata0, rdata1;

  wire         m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  wire  [31:0] m_awaddr, m_wdata, m_araddr;
  wire  [2:0]  m_awprot, m_arprot;
  wire  [3:0]  m_wstrb;
  logic        m_awready, m_wready, m_arready, m_bvalid, m_rvalid;
  logic [31:0] m_rdata;

  always #5 clk_i = ~clk_i;

  axil_arbiter_2to1 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s0_awvalid(awvalid[0]), .s0_awready(awready[0]), .s0_awaddr(awaddr[0]), .s0_awprot(awprot[0]),
    .s0_wvalid(wvalid[0]), .s0_wready(wready[0]), .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]),
    .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
    .s0_arvalid(arvalid[0]), .s0_arready(arready[0]), .s0_araddr(araddr[0]), .s0_arprot(arprot[0]),
    .s0_rvalid(rvalid[0]), .s0_rready(rready[0]), .s0_rdata(rdata0),
    .s1_awvalid(awvalid[1]), .s1_awready(awready[1]), .s1_awaddr(awaddr[1]), .s1_awprot(awprot[1]),
    .s1_wvalid(wvalid[1]), .s1_wready(wready[1]), .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]),
    .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
    .s1_arvalid(arvalid[1]), .s1_arready(arready[1]), .s1_araddr(araddr[1]), .s1_arprot(arprot[1]),
    .s1_rvalid(rvalid[1]), .s1_rready(rready[1]), .s1_rdata(rdata1),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // transaction lists per port and the predicted downstream order
  item_t plist [2][16];
  int    pcnt [2];
  int    pidx [2];
  item_t exp_q [$];
  int    exp_wr [2];
  int    exp_rd [2];

  // master agent state
  bit    wr_act [2], rd_act [2], aw_pend [2], w_pend [2], b_wait [2], ar_pend [2], r_wait [2];
  item_t wr_it [2], rd_it [2];
  int    bcnt [2], rcnt [2];
  logic [31:0] last_rdata [2];

  // slave agent state
  int    f_aw = -1, f_w = -1, f_ar = -1, f_r = -1, f_b = -1;
  bit    spur_en;
  int    aw_cnt, w_cnt, ar_cnt, aw_dly, w_dly, ar_dly;
  bit    got_aw, got_w, r_pend, b_pend;
  int    r_timer, b_timer;
  logic [31:0] r_val, sl_awaddr, sl_wdata;
  logic [2:0]  sl_awprot;
  logic [3:0]  sl_wstrb;

  int cyc_g, prev_done;
  bit have_prev, in_txn;

  function automatic int pick_dly(input int f);
    return (f >= 0) ? f : int'($urandom_range(3, 0));
  endfunction

  function automatic logic [14:0] all_outs();
    return {awready, wready, bvalid, arready, rvalid,
            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready};
  endfunction

  task automatic add_item(input int p, input logic wr, input logic pair, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
    item_t it;
    it.wr = wr; it.pair = pair; it.port = p[0]; it.prot = prot;
    it.strb = strb; it.addr = addr; it.data = data;
    plist[p][pcnt[p]] = it;
    pcnt[p]++;
  endtask

  // item-level round robin: both ports have work -> the one not served last goes next
  task automatic build_expected();
    int  i0, i1, pick;
    int  last;
    i0 = 0; i1 = 0; last = 1;
    exp_q.delete();
    exp_wr = '{0, 0}; exp_rd = '{0, 0};
    while (i0 < pcnt[0] || i1 < pcnt[1]) begin
      if (i0 < pcnt[0] && i1 < pcnt[1]) pick = 1 - last;
      else pick = (i1 < pcnt[1]) ? 1 : 0;
      if (pick == 0) begin exp_q.push_back(plist[0][i0]); i0++; end
      else begin exp_q.push_back(plist[1][i1]); i1++; end
      if (exp_q[$].wr) exp_wr[pick]++; else exp_rd[pick]++;
      last = pick;
    end
  endtask

  task automatic pop_expected(output item_t it);
    if (exp_q.size() == 0) begin
      check("exp_underflow", 1, 0);
      it = '0;
    end else begin
      it = exp_q.pop_front();
    end
  endtask

  task automatic clear_agents();
    for (int p = 0; p < 2; p++) begin
      wr_act[p] = 0; rd_act[p] = 0; aw_pend[p] = 0; w_pend[p] = 0; b_wait[p] = 0;
      ar_pend[p] = 0; r_wait[p] = 0; pcnt[p] = 0; pidx[p] = 0; bcnt[p] = 0; rcnt[p] = 0;
      wr_it[p] = '0; rd_it[p] = '0; last_rdata[p] = '0;
      awaddr[p] = '0; awprot[p] = '0; wdata[p] = '0; wstrb[p] = '0; araddr[p] = '0; arprot[p] = '0;
    end
    awvalid = '0; wvalid = '0; arvalid = '0; bready = '0; rready = '0;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; m_rdata = '0;
    got_aw = 0; got_w = 0; r_pend = 0; b_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_dly = pick_dly(f_aw); w_dly = pick_dly(f_w); ar_dly = pick_dly(f_ar);
    in_txn = 0; have_prev = 0;
    exp_q.delete();
  endtask

  // reset with every input asserted: outputs must still be all zero
  task automatic do_reset();
    rst_i = 1;
    awvalid = '1; wvalid = '1; arvalid = '1; bready = '1; rready = '1;
    m_awready = 1; m_wready = 1; m_arready = 1; m_bvalid = 1; m_rvalid = 1; m_rdata = $urandom;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", all_outs(), 0);
    clear_agents();
    @(posedge clk_i);
    #1 rst_i = 0;
  endtask

  // everything observed here is what the next rising edge will act on
  task automatic sample();
    item_t it;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("p%0d_stray_out", p),
            {awready[p] & ~aw_pend[p], wready[p] & ~w_pend[p], bvalid[p] & ~b_wait[p],
             arready[p] & ~ar_pend[p], rvalid[p] & ~r_wait[p]}, 0);
    end
    check("port_exclusive", (|{awready[0], wready[0], bvalid[0], arready[0], rvalid[0]}) &
                            (|{awready[1], wready[1], bvalid[1], arready[1], rvalid[1]}), 0);
    if (m_rvalid && !r_pend) check("stray_rready", m_rready, 0);
    if (m_bvalid && !b_pend) check("stray_bready", m_bready, 0);

    if ((m_awvalid || m_wvalid || m_arvalid) && !in_txn) begin
      in_txn = 1;
      if (have_prev) check("issue_latency", cyc_g - prev_done, 2);
    end

    if (m_arvalid && m_arready) begin
      pop_expected(it);
      check("ar_kind", it.wr, 0);
      check("ar_addr", m_araddr, it.addr);
      check("ar_prot", m_arprot, it.prot);
      r_pend = 1; r_timer = pick_dly(f_r); r_val = m_araddr ^ RD_KEY;
      ar_cnt = 0; ar_dly = pick_dly(f_ar);
    end else if (m_arvalid) ar_cnt++;

    if (m_awvalid && m_awready) begin
      check("aw_once", got_aw, 0);
      got_aw = 1; sl_awaddr = m_awaddr; sl_awprot = m_awprot;
      aw_cnt = 0; aw_dly = pick_dly(f_aw);
    end else if (m_awvalid) aw_cnt++;

    if (m_wvalid && m_wready) begin
      check("w_once", got_w, 0);
      got_w = 1; sl_wdata = m_wdata; sl_wstrb = m_wstrb;
      w_cnt = 0; w_dly = pick_dly(f_w);
    end else if (m_wvalid) w_cnt++;

    if (got_aw && got_w) begin
      pop_expected(it);
      check("wr_kind", it.wr, 1);
      check("wr_addr", sl_awaddr, it.addr);
      check("wr_prot", sl_awprot, it.prot);
      check("wr_data", sl_wdata, it.data);
      check("wr_strb", sl_wstrb, it.strb);
      got_aw = 0; got_w = 0; b_pend = 1; b_timer = pick_dly(f_b);
    end

    if (m_rvalid && m_rready && r_pend) begin
      r_pend = 0; in_txn = 0; prev_done = cyc_g; have_prev = 1;
    end
    if (m_bvalid && m_bready && b_pend) begin
      b_pend = 0; in_txn = 0; prev_done = cyc_g; have_prev = 1;
    end

    for (int p = 0; p < 2; p++) begin
      if (bvalid[p] && bready[p] && b_wait[p]) begin
        b_wait[p] = 0; wr_act[p] = 0; bcnt[p]++;
      end
      if (rvalid[p] && rready[p] && r_wait[p]) begin
        last_rdata[p] = (p == 0) ? rdata0 : rdata1;
        check($sformatf("p%0d_rdata", p), last_rdata[p], rd_it[p].addr ^ RD_KEY);
        r_wait[p] = 0; rd_act[p] = 0; rcnt[p]++;
      end
      if (awvalid[p] && awready[p]) aw_pend[p] = 0;
      if (wvalid[p] && wready[p]) w_pend[p] = 0;
      if (arvalid[p] && arready[p]) begin ar_pend[p] = 0; r_wait[p] = 1; end
      if (wr_act[p] && !aw_pend[p] && !w_pend[p]) b_wait[p] = 1;
    end
  endtask

  task automatic drive();
    item_t it;
    for (int p = 0; p < 2; p++) begin
      if (!wr_act[p] && !rd_act[p] && pidx[p] < pcnt[p]) begin
        it = plist[p][pidx[p]];
        pidx[p]++;
        if (it.wr) begin
          wr_act[p] = 1; aw_pend[p] = 1; w_pend[p] = 1; wr_it[p] = it;
          if (it.pair) begin
            rd_it[p] = plist[p][pidx[p]]; pidx[p]++; rd_act[p] = 1; ar_pend[p] = 1;
          end
        end else begin
          rd_act[p] = 1; ar_pend[p] = 1; rd_it[p] = it;
        end
      end
      awvalid[p] = aw_pend[p]; wvalid[p] = w_pend[p]; arvalid[p] = ar_pend[p];
      awaddr[p] = wr_it[p].addr; awprot[p] = wr_it[p].prot;
      wdata[p] = wr_it[p].data; wstrb[p] = wr_it[p].strb;
      araddr[p] = rd_it[p].addr; arprot[p] = rd_it[p].prot;
      bready[p] = ($urandom_range(3, 0) != 0);
      rready[p] = ($urandom_range(3, 0) != 0);
    end
    m_awready = (aw_cnt >= aw_dly);
    m_wready  = (w_cnt >= w_dly);
    m_arready = (ar_cnt >= ar_dly);
    if (r_pend) begin
      if (r_timer > 0) begin r_timer--; m_rvalid = 0; end
      else begin m_rvalid = 1; m_rdata = r_val; end
    end else begin
      m_rvalid = spur_en && ($urandom_range(7, 0) == 0);
      m_rdata = $urandom;
    end
    if (b_pend) begin
      if (b_timer > 0) begin b_timer--; m_bvalid = 0; end
      else m_bvalid = 1;
    end else begin
      m_bvalid = spur_en && ($urandom_range(7, 0) == 0);
    end
  endtask

  function automatic bit all_done();
    return pidx[0] == pcnt[0] && pidx[1] == pcnt[1] &&
           !wr_act[0] && !rd_act[0] && !wr_act[1] && !rd_act[1] &&
           !b_pend && !r_pend && !got_aw && !got_w;
  endfunction

  task automatic run_phase(input int max_cyc, input bit stop_on_ar);
    bit finished;
    finished = 0;
    for (int c = 0; c < max_cyc && !finished; c++) begin
      @(negedge clk_i);
      cyc_g++;
      sample();
      if (!stop_on_ar) finished = all_done();
      @(posedge clk_i);
      #1;
      drive();
      if (stop_on_ar && r_pend) finished = 1;
    end
    if (!finished) check("phase_timeout", 1, 0);
    if (!stop_on_ar) begin
      check("exp_drained", exp_q.size(), 0);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("p%0d_bcount", p), bcnt[p], exp_wr[p]);
        check($sformatf("p%0d_rcount", p), rcnt[p], exp_rd[p]);
      end
    end
  endtask

  task automatic random_phase();
    int k;
    logic [31:0] a;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      while (pcnt[p] < 12) begin
        k = $urandom_range(2, 0);
        a = {3'b000, p[0], 28'($urandom)} & 32'hFFFF_FFFC;
        if (k == 0) add_item(p, 0, 0, a, 0, 0, 3'($urandom));
        else if (k == 1) add_item(p, 1, 0, a, $urandom, 4'($urandom), 3'($urandom));
        else begin
          add_item(p, 1, 1, a, $urandom, 4'($urandom), 3'($urandom));
          add_item(p, 0, 0, a ^ 32'h0000_0100, 0, 0, 3'($urandom));
        end
      end
    end
    build_expected();
    run_phase(2000, 0);
  endtask

  initial begin
    spur_en = 0;
    cyc_g = 0;
    prev_done = 0;
    clear_agents();

    // single read through a slow AR channel
    f_ar = 2;
    do_reset();
    add_item(0, 0, 0, 32'h0300_3000, 0, 0, 3'b010);
    build_expected();
    run_phase(200, 0);
    check("p0_rdata_deadbeef", last_rdata[0], 32'hDEAD_BEEF);
    f_ar = -1;

    // simultaneous reads after reset: port 0 first
    do_reset();
    add_item(0, 0, 0, 32'h0300_1000, 0, 0, 3'b000);
    add_item(1, 0, 0, 32'h0300_2000, 0, 0, 3'b001);
    build_expected();
    run_phase(200, 0);

    // write with W accepted three cycles before AW
    f_w = 0; f_aw = 3;
    do_reset();
    add_item(1, 1, 0, 32'h0300_7004, 32'h1234_5678, 4'hF, 3'b000);
    build_expected();
    run_phase(200, 0);
    f_w = -1; f_aw = -1;

    // write and read raised together on one port: write goes first
    do_reset();
    add_item(0, 1, 1, 32'h0300_0100, 32'hA5A5_5A5A, 4'hF, 3'b000);
    add_item(0, 0, 0, 32'h0300_0200, 0, 0, 3'b000);
    build_expected();
    run_phase(200, 0);

    // four writes from each port, continuously
    do_reset();
    for (int i = 0; i < 4; i++) begin
      add_item(0, 1, 0, 32'h0300_0000 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 3'b000);
      add_item(1, 1, 0, 32'h0310_0000 + 32'(i * 4), 32'h2000_0000 + 32'(i), 4'h3, 3'b000);
    end
    build_expected();
    run_phase(400, 0);

    // randomized mixes with stray downstream responses
    spur_en = 1;
    for (int r = 0; r < 3; r++) random_phase();
    spur_en = 0;

    // reset while waiting in the read-data phase
    f_r = 1000;
    do_reset();
    add_item(0, 0, 0, 32'h0300_4000, 0, 0, 3'b000);
    build_expected();
    run_phase(50, 1);
    rready = '1;
    bready = '1;
    rst_i = 1;
    @(negedge clk_i);
    check("mid_reset_outputs", all_outs(), 0);
    f_r = -1;
    clear_agents();
    @(posedge clk_i);
    #1 rst_i = 0;
    add_item(1, 0, 0, 32'h0300_5000, 0, 0, 3'b000);
    build_expected();
    run_phase(200, 0);
    check("p1_rdata_after_reset", last_rdata[1], 32'h0300_5000 ^ RD_KEY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
